// File: rtl/cpu_trace_buffer.sv
// Trace capture for the single-cycle CPU: records NUM_CH probe channels per enabled cycle
// into a circular buffer, stops on full or after a PC trigger, and reads samples oldest-first.
module cpu_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic [ADDR_W-1:0]        post_cnt,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_idx,
  input  logic [CH_W-1:0]          rd_ch,
  output logic                     rd_valid,
  output logic                     rd_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W:0]          count,
  output logic [CNT_W-1:0]         total,
  output logic [1:0]               state_o,
  output logic                     triggered
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [CH_W:0]   NUM_CH_C = (CH_W+1)'(NUM_CH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [ADDR_W-1:0]   remain_q, remain_d;
  logic                trig_q, trig_d;
  logic                rd_valid_q, rd_err_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic [NUM_CH*DATA_W-1:0] mem [DEPTH];

  logic                     wr_en;
  logic                     pc_match;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_bad;
  logic [NUM_CH*DATA_W-1:0] rd_word;
  logic [DATA_W-1:0]        rd_sel;

  assign wr_en    = cap_en && (state_q != S_DONE);
  assign pc_match = trig_en && (ch_data[DATA_W-1:0] == trig_pc);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    total_d  = total_q;
    remain_d = remain_q;
    trig_d   = trig_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = (count_q == DEPTH_C) ? count_q : count_q + (ADDR_W+1)'(1);
      total_d  = total_q + CNT_W'(1);
      unique case (state_q)
        S_IDLE, S_CAPTURE: begin
          state_d = S_CAPTURE;
          // a trigger on the same write that fills the buffer wins over stop-on-full
          if (pc_match) begin
            trig_d   = 1'b1;
            remain_d = post_cnt;
            state_d  = (post_cnt == '0) ? S_DONE : S_POST;
          end else if (mode && (count_d == DEPTH_C)) begin
            state_d = S_DONE;
          end
        end
        S_POST: begin
          remain_d = remain_q - ADDR_W'(1);
          if (remain_q == ADDR_W'(1)) state_d = S_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // once the buffer has wrapped, the oldest sample sits at the write pointer
  assign rd_addr = (count_q < DEPTH_C) ? rd_idx : wr_ptr_q + rd_idx;
  assign rd_bad  = ({1'b0, rd_idx} >= count_q) || ({1'b0, rd_ch} >= NUM_CH_C);
  assign rd_word = mem[rd_addr];

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == CH_W'(k)) rd_sel = rd_word[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst && !clr) mem[wr_ptr_q] <= ch_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      total_q    <= '0;
      remain_q   <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else if (clr) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      total_q    <= '0;
      remain_q   <= '0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      total_q    <= total_d;
      remain_q   <= remain_d;
      trig_q     <= trig_d;
      rd_valid_q <= rd_req;
      rd_err_q   <= rd_req && rd_bad;
      if (rd_req) rd_data_q <= rd_bad ? '0 : rd_sel;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign total     = total_q;
  assign state_o   = state_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with DEPTH=4, NUM_CH=4; channel k = PC + 0x100*k.
module tb_cpu_trace_buffer;

  logic         clk;
  logic         rst, clr, cap_en, mode, trig_en;
  logic [31:0]  trig_pc;
  logic [1:0]   post_cnt;
  logic [127:0] ch_data;
  logic         rd_req;
  logic [1:0]   rd_idx;
  logic [1:0]   rd_ch;
  logic         rd_valid, rd_err;
  logic [31:0]  rd_data;
  logic [2:0]   count;
  logic [31:0]  total;
  logic [1:0]   state_o;
  logic         triggered;

  int checks = 0;
  int failures = 0;

  cpu_trace_buffer #(
    .DATA_W(32), .NUM_CH(4), .DEPTH(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .ch_data(ch_data), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ch(rd_ch),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_data(rd_data),
    .count(count), .total(total), .state_o(state_o), .triggered(triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    ch_data = {pc + 32'h300, pc + 32'h200, pc + 32'h100, pc};
  endtask

  task automatic write_pc(input logic [31:0] pc);
    set_pc(pc);
    cap_en = 1'b1;
    tick();
    cap_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] idx, input logic [1:0] ch,
                          input logic err, input logic [31:0] data);
    rd_req = 1'b1;
    rd_idx = idx;
    rd_ch  = ch;
    tick();
    rd_req = 1'b0;
    chk_eq({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk_eq({tag, "_err"}, {31'd0, rd_err}, {31'd0, err});
    chk_eq({tag, "_data"}, rd_data, data);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; cap_en = 1'b1; mode = 1'b0; trig_en = 1'b0;
    trig_pc = '0; post_cnt = '0; rd_req = 1'b0; rd_idx = '0; rd_ch = '0;
    set_pc(32'h0);

    // 1. reset with cap_en high
    tick();
    tick();
    rst = 1'b0;
    cap_en = 1'b0;
    chk_eq("rst_count", {29'd0, count}, 32'd0);
    chk_eq("rst_total", total, 32'd0);
    chk_eq("rst_state", {30'd0, state_o}, 32'd0);
    chk_eq("rst_trig", {31'd0, triggered}, 32'd0);
    chk_eq("rst_rdvalid", {31'd0, rd_valid}, 32'd0);
    read_chk("rst_rd", 2'd0, 2'd0, 1'b1, 32'h0);

    // 2. wrap mode, six writes
    for (int i = 0; i < 6; i++) write_pc(32'(i * 4));
    chk_eq("wrap_count", {29'd0, count}, 32'd4);
    chk_eq("wrap_total", total, 32'd6);
    chk_eq("wrap_state", {30'd0, state_o}, 32'd1);
    chk_eq("wrap_trig", {31'd0, triggered}, 32'd0);
    // back-to-back pipelined reads
    rd_req = 1'b1; rd_idx = 2'd0; rd_ch = 2'd0;
    tick();
    chk_eq("wrap_p0_valid", {31'd0, rd_valid}, 32'd1);
    chk_eq("wrap_p0_data", rd_data, 32'h08);
    rd_idx = 2'd3;
    tick();
    chk_eq("wrap_p1_valid", {31'd0, rd_valid}, 32'd1);
    chk_eq("wrap_p1_data", rd_data, 32'h14);
    rd_ch = 2'd2;
    tick();
    rd_req = 1'b0;
    chk_eq("wrap_p2_err", {31'd0, rd_err}, 32'd0);
    chk_eq("wrap_p2_data", rd_data, 32'h214);
    tick();
    chk_eq("wrap_idle_valid", {31'd0, rd_valid}, 32'd0);

    // clr keeps rd_data, clears everything else
    do_clr();
    chk_eq("clr_state", {30'd0, state_o}, 32'd0);
    chk_eq("clr_count", {29'd0, count}, 32'd0);
    chk_eq("clr_total", total, 32'd0);
    chk_eq("clr_rddata_hold", rd_data, 32'h214);

    // 3. stop when full
    mode = 1'b1;
    for (int i = 0; i < 3; i++) write_pc(32'(i * 4));
    chk_eq("full_state3", {30'd0, state_o}, 32'd1);
    write_pc(32'h0C);
    chk_eq("full_state4", {30'd0, state_o}, 32'd3);
    write_pc(32'h10);
    write_pc(32'h14);
    chk_eq("full_total", total, 32'd4);
    chk_eq("full_count", {29'd0, count}, 32'd4);
    chk_eq("full_state6", {30'd0, state_o}, 32'd3);
    read_chk("full_rd0", 2'd0, 2'd0, 1'b0, 32'h00);
    read_chk("full_rd3", 2'd3, 2'd0, 1'b0, 32'h0C);

    // 4. trigger with post count and a pause mid-POST
    do_clr();
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h10; post_cnt = 2'd2;
    for (int i = 0; i < 4; i++) write_pc(32'(i * 4));
    chk_eq("trg_pre_state", {30'd0, state_o}, 32'd1);
    chk_eq("trg_pre_trig", {31'd0, triggered}, 32'd0);
    write_pc(32'h10);
    chk_eq("trg_hit_trig", {31'd0, triggered}, 32'd1);
    chk_eq("trg_hit_state", {30'd0, state_o}, 32'd2);
    tick(); tick(); tick();
    chk_eq("trg_pause_state", {30'd0, state_o}, 32'd2);
    write_pc(32'h14);
    chk_eq("trg_p1_state", {30'd0, state_o}, 32'd2);
    write_pc(32'h18);
    chk_eq("trg_done_state", {30'd0, state_o}, 32'd3);
    write_pc(32'h1C);
    chk_eq("trg_total", total, 32'd7);
    chk_eq("trg_count", {29'd0, count}, 32'd4);
    read_chk("trg_rd0", 2'd0, 2'd0, 1'b0, 32'h0C);
    read_chk("trg_rd1", 2'd1, 2'd0, 1'b0, 32'h10);
    read_chk("trg_rd2", 2'd2, 2'd0, 1'b0, 32'h14);
    read_chk("trg_rd3", 2'd3, 2'd0, 1'b0, 32'h18);

    // 5. trigger on the very first write with post_cnt=0
    do_clr();
    trig_pc = 32'h40; post_cnt = 2'd0;
    write_pc(32'h40);
    chk_eq("edge_state", {30'd0, state_o}, 32'd3);
    chk_eq("edge_count", {29'd0, count}, 32'd1);
    chk_eq("edge_trig", {31'd0, triggered}, 32'd1);
    chk_eq("edge_total", total, 32'd1);
    read_chk("edge_rd_ch3", 2'd0, 2'd3, 1'b0, 32'h340);
    read_chk("edge_rd_idx1", 2'd1, 2'd0, 1'b1, 32'h0);

    // 6a. reset while in POST with a read pending
    do_clr();
    trig_pc = 32'h08; post_cnt = 2'd3;
    write_pc(32'h00);
    write_pc(32'h04);
    write_pc(32'h08);
    chk_eq("mid_post_state", {30'd0, state_o}, 32'd2);
    read_chk("mid_rd", 2'd0, 2'd1, 1'b0, 32'h100);
    rst = 1'b1; rd_req = 1'b1; rd_idx = 2'd0; rd_ch = 2'd0;
    tick();
    rst = 1'b0; rd_req = 1'b0;
    chk_eq("mid_rst_state", {30'd0, state_o}, 32'd0);
    chk_eq("mid_rst_count", {29'd0, count}, 32'd0);
    chk_eq("mid_rst_trig", {31'd0, triggered}, 32'd0);
    chk_eq("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk_eq("mid_rst_data", rd_data, 32'h0);

    // 6b. clear from DONE, capture resumes
    mode = 1'b1; trig_en = 1'b0;
    for (int i = 0; i < 4; i++) write_pc(32'(i * 4));
    chk_eq("cd_done_state", {30'd0, state_o}, 32'd3);
    do_clr();
    chk_eq("cd_clr_state", {30'd0, state_o}, 32'd0);
    write_pc(32'h80);
    chk_eq("cd_resume_state", {30'd0, state_o}, 32'd1);
    chk_eq("cd_resume_count", {29'd0, count}, 32'd1);
    read_chk("cd_rd", 2'd0, 2'd1, 1'b0, 32'h180);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
